// File: rtl/i2c_xfer_seq_pkg.sv
// rtl/i2c_xfer_seq_pkg.sv - shared byte-controller command codes, sequencer states and ACK levels
package i2c_xfer_seq_pkg;

  localparam logic [3:0] CMD_IDLE    = 4'd0;
  localparam logic [3:0] CMD_START   = 4'd1;
  localparam logic [3:0] CMD_RESTART = 4'd2;
  localparam logic [3:0] CMD_STOP    = 4'd3;
  localparam logic [3:0] CMD_WRITE   = 4'd4;
  localparam logic [3:0] CMD_READ    = 4'd5;
  localparam logic [3:0] CMD_RD_ACK  = 4'd6;
  localparam logic [3:0] CMD_WR_ACK  = 4'd7;

  // SDA level driven by the master during CMD_WR_ACK
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    SEQ_IDLE, SEQ_START, SEQ_DADDR_W, SEQ_ACK_DW, SEQ_RADDR, SEQ_ACK_RA,
    SEQ_WDATA, SEQ_ACK_WD, SEQ_RESTART, SEQ_DADDR_R, SEQ_ACK_DR,
    SEQ_RDATA, SEQ_WACK, SEQ_STOP, SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/i2c_cmd_issue.sv
// rtl/i2c_cmd_issue.sv - command strobe, ack edge detect and outstanding flag; watchdog under I2C_TIMEOUT_EN
module i2c_cmd_issue #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic s_sysclk,
  input  logic s_nReset,
  input  logic clr_i,
  input  logic issue_i,
  input  logic cmd_ack_i,
  output logic trig_o,
  output logic ack_edge_o,
  output logic pend_o,
  output logic timeout_o
);

  logic ack_q;
  logic pend_q;

  assign trig_o     = issue_i & ~pend_q & ~clr_i;
  assign ack_edge_o = cmd_ack_i & ~ack_q & pend_q;
  assign pend_o     = pend_q;

  always_ff @(posedge s_sysclk or negedge s_nReset) begin
    if (!s_nReset) begin
      ack_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ack_q <= cmd_ack_i;
      if (clr_i || ack_edge_o) pend_q <= 1'b0;
      else if (trig_o)         pend_q <= 1'b1;
    end
  end

`ifdef I2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;

  always_ff @(posedge s_sysclk or negedge s_nReset) begin
    if (!s_nReset)                           wd_q <= '0;
    else if (clr_i || ack_edge_o)            wd_q <= '0;
    else if (trig_o)                         wd_q <= TW'(1);
    else if (pend_q && wd_q != TW'(TIMEOUT_CYC)) wd_q <= wd_q + 1'b1;
  end

  assign timeout_o = pend_q && (wd_q == TW'(TIMEOUT_CYC));
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/i2c_xfer_seq.sv
// rtl/i2c_xfer_seq.sv - I2C register transfer sequencer over the byte controller; watchdog via I2C_TIMEOUT_EN
import i2c_xfer_seq_pkg::*;

module i2c_xfer_seq #(
  parameter int RA_BYTES    = 1,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  s_sysclk,
  input  logic                  s_nReset,
  input  logic                  i_enable,
  input  logic                  i_go,
  input  logic                  i_rw,
  input  logic [6:0]            i_dev_addr,
  input  logic [8*RA_BYTES-1:0] i_reg_addr,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [7:0]            i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [7:0]            o_rdata,
  output logic                  o_rvalid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_nack,
  output logic                  o_al,
  output logic                  o_timeout,
  output logic                  o_cmd_trig,
  output logic [3:0]            o_cmd,
  output logic [7:0]            o_data,
  input  logic                  i_cmd_ack,
  input  logic                  i_i2c_ack,
  input  logic                  i_i2c_al,
  input  logic [7:0]            i_data
);

  seq_state_e state_q, state_d;
  logic rw_q, rw_d, ra_q, ra_d, wfull_q, wfull_d;
  logic nack_q, nack_d, al_q, al_d, to_q, to_d;
  logic [6:0] dev_q, dev_d;
  logic [8*RA_BYTES-1:0] reg_q, reg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0] wbuf_q, wbuf_d, raddr_byte;
  logic cmd_state, last_ra, ack_edge, pend, wd_expired;

  assign cmd_state  = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
  assign last_ra    = (RA_BYTES == 1) || ra_q;
  assign raddr_byte = (RA_BYTES == 2 && !ra_q) ? reg_q[8*RA_BYTES-1 -: 8] : reg_q[7:0];

  // In WDATA the command waits for a buffered byte, so an underrun simply holds the bus
  i2c_cmd_issue #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_issue (
    .s_sysclk  (s_sysclk),
    .s_nReset  (s_nReset),
    .clr_i     (~i_enable | ~cmd_state),
    .issue_i   (cmd_state && i_enable && (state_q != SEQ_WDATA || wfull_q)),
    .cmd_ack_i (i_cmd_ack),
    .trig_o    (o_cmd_trig),
    .ack_edge_o(ack_edge),
    .pend_o    (pend),
    .timeout_o (wd_expired)
  );

  assign o_busy    = (state_q != SEQ_IDLE);
  assign o_done    = (state_q == SEQ_DONE);
  assign o_wready  = (state_q == SEQ_WDATA) && !pend && !wfull_q && i_enable;
  assign o_rvalid  = (state_q == SEQ_RDATA) && ack_edge && !i_i2c_al && i_enable;
  assign o_rdata   = o_rvalid ? i_data : 8'h00;
  assign o_nack    = nack_q;
  assign o_al      = al_q;
  assign o_timeout = to_q;

  always_comb begin
    o_cmd  = CMD_IDLE;
    o_data = 8'h00;
    case (state_q)
      SEQ_START:   o_cmd = CMD_START;
      SEQ_DADDR_W: begin o_cmd = CMD_WRITE; o_data = {dev_q, 1'b0}; end
      SEQ_RADDR:   begin o_cmd = CMD_WRITE; o_data = raddr_byte; end
      SEQ_WDATA:   begin o_cmd = CMD_WRITE; o_data = wbuf_q; end
      SEQ_RESTART: o_cmd = CMD_RESTART;
      SEQ_DADDR_R: begin o_cmd = CMD_WRITE; o_data = {dev_q, 1'b1}; end
      SEQ_RDATA:   o_cmd = CMD_READ;
      SEQ_WACK:    begin o_cmd = CMD_WR_ACK; o_data = {7'd0, (cnt_q == LEN_W'(1)) ? I2C_NACK : I2C_ACK}; end
      SEQ_STOP:    o_cmd = CMD_STOP;
      SEQ_ACK_DW, SEQ_ACK_RA, SEQ_ACK_WD, SEQ_ACK_DR: o_cmd = CMD_RD_ACK;
      default:     o_cmd = CMD_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q; rw_d = rw_q; dev_d = dev_q; reg_d = reg_q; cnt_d = cnt_q; ra_d = ra_q;
    wbuf_d = wbuf_q; wfull_d = 1'b0; nack_d = nack_q; al_d = al_q; to_d = to_q;
    if (state_q == SEQ_WDATA) begin
      wfull_d = wfull_q & ~o_cmd_trig;
      if (i_wvalid && o_wready) begin wbuf_d = i_wdata; wfull_d = 1'b1; end
    end
    case (state_q)
      SEQ_IDLE: if (i_go && i_enable) begin
        rw_d = i_rw; dev_d = i_dev_addr; reg_d = i_reg_addr; cnt_d = i_len; ra_d = 1'b0;
        nack_d = 1'b0; al_d = 1'b0; to_d = 1'b0; state_d = SEQ_START;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default: if (ack_edge) begin
        case (state_q)
          SEQ_START:   state_d = SEQ_DADDR_W;
          SEQ_DADDR_W: state_d = SEQ_ACK_DW;
          SEQ_ACK_DW:  state_d = SEQ_RADDR;
          SEQ_RADDR:   state_d = SEQ_ACK_RA;
          SEQ_ACK_RA:
            if (!last_ra)             begin ra_d = 1'b1; state_d = SEQ_RADDR; end
            else if (cnt_q == '0)     state_d = SEQ_STOP;
            else                      state_d = rw_q ? SEQ_RESTART : SEQ_WDATA;
          SEQ_WDATA:   state_d = SEQ_ACK_WD;
          SEQ_ACK_WD:
            if (cnt_q == LEN_W'(1)) state_d = SEQ_STOP;
            else begin cnt_d = cnt_q - 1'b1; state_d = SEQ_WDATA; end
          SEQ_RESTART: state_d = SEQ_DADDR_R;
          SEQ_DADDR_R: state_d = SEQ_ACK_DR;
          SEQ_ACK_DR:  state_d = SEQ_RDATA;
          SEQ_RDATA:   state_d = SEQ_WACK;
          SEQ_WACK:
            if (cnt_q == LEN_W'(1)) state_d = SEQ_STOP;
            else begin cnt_d = cnt_q - 1'b1; state_d = SEQ_RDATA; end
          SEQ_STOP:    state_d = SEQ_DONE;
          default:     state_d = state_q;
        endcase
        if (state_q inside {SEQ_ACK_DW, SEQ_ACK_RA, SEQ_ACK_WD, SEQ_ACK_DR} && !i_i2c_ack) begin
          nack_d  = 1'b1;
          state_d = SEQ_STOP;
        end
      end
    endcase
    // Lost arbitration or a dead controller means we no longer own the bus: skip STOP
    if (cmd_state && i_i2c_al) begin
      al_d = 1'b1; state_d = SEQ_DONE;
    end else if (cmd_state && wd_expired) begin
      to_d = 1'b1; state_d = SEQ_DONE;
    end
    if (!i_enable) state_d = SEQ_IDLE;
  end

  always_ff @(posedge s_sysclk or negedge s_nReset) begin
    if (!s_nReset) begin
      state_q <= SEQ_IDLE; rw_q <= 1'b0; dev_q <= '0; reg_q <= '0; cnt_q <= '0; ra_q <= 1'b0;
      wbuf_q <= '0; wfull_q <= 1'b0; nack_q <= 1'b0; al_q <= 1'b0; to_q <= 1'b0;
    end else begin
      state_q <= state_d; rw_q <= rw_d; dev_q <= dev_d; reg_q <= reg_d; cnt_q <= cnt_d; ra_q <= ra_d;
      wbuf_q <= wbuf_d; wfull_q <= wfull_d; nack_q <= nack_d; al_q <= al_d; to_q <= to_d;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb/tb_i2c_xfer_seq.sv - scoreboard bench for i2c_xfer_seq with a byte-controller model; timeout case under I2C_TIMEOUT_EN
module tb_i2c_xfer_seq;
  import i2c_xfer_seq_pkg::*;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic enable, go, rw, wvalid, cmd_ack, i2c_ack, i2c_al;
  logic [6:0] dev;
  logic [15:0] reg16;
  logic [3:0] len;
  logic [7:0] wdata, idata;
  bit sel;

  logic wready0, rvalid0, busy0, done0, nack0, al0, to0, trig0;
  logic wready1, rvalid1, busy1, done1, nack1, al1, to1, trig1;
  logic [7:0] rdata0, data0, rdata1, data1;
  logic [3:0] cmd0, cmd1;

  i2c_xfer_seq #(.RA_BYTES(1), .LEN_W(4), .TIMEOUT_CYC(64)) dut0 (
    .s_sysclk(clk), .s_nReset(rstn), .i_enable(enable), .i_go(go & ~sel), .i_rw(rw),
    .i_dev_addr(dev), .i_reg_addr(reg16[7:0]), .i_len(len), .i_wdata(wdata), .i_wvalid(wvalid),
    .o_wready(wready0), .o_rdata(rdata0), .o_rvalid(rvalid0), .o_busy(busy0), .o_done(done0),
    .o_nack(nack0), .o_al(al0), .o_timeout(to0), .o_cmd_trig(trig0), .o_cmd(cmd0), .o_data(data0),
    .i_cmd_ack(cmd_ack), .i_i2c_ack(i2c_ack), .i_i2c_al(i2c_al), .i_data(idata));

  i2c_xfer_seq #(.RA_BYTES(2), .LEN_W(4), .TIMEOUT_CYC(64)) dut1 (
    .s_sysclk(clk), .s_nReset(rstn), .i_enable(enable), .i_go(go & sel), .i_rw(rw),
    .i_dev_addr(dev), .i_reg_addr(reg16), .i_len(len), .i_wdata(wdata), .i_wvalid(wvalid),
    .o_wready(wready1), .o_rdata(rdata1), .o_rvalid(rvalid1), .o_busy(busy1), .o_done(done1),
    .o_nack(nack1), .o_al(al1), .o_timeout(to1), .o_cmd_trig(trig1), .o_cmd(cmd1), .o_data(data1),
    .i_cmd_ack(cmd_ack), .i_i2c_ack(i2c_ack), .i_i2c_al(i2c_al), .i_data(idata));

  logic wready, rvalid, busy, done, nack, al, tmo, trig;
  logic [7:0] rdata, data;
  logic [3:0] cmd;
  assign wready = sel ? wready1 : wready0;
  assign rvalid = sel ? rvalid1 : rvalid0;
  assign busy   = sel ? busy1 : busy0;
  assign done   = sel ? done1 : done0;
  assign nack   = sel ? nack1 : nack0;
  assign al     = sel ? al1 : al0;
  assign tmo    = sel ? to1 : to0;
  assign trig   = sel ? trig1 : trig0;
  assign rdata  = sel ? rdata1 : rdata0;
  assign data   = sel ? data1 : data0;
  assign cmd    = sel ? cmd1 : cmd0;

  int checks = 0, errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0] rexp_q[$], slave_q[$], wq[$];
  int trig_n = 0, done_n = 0, rdack_n = 0, wr_n = 0, nack_at = -1, al_at = -1;
  int wsent = 0, gap_at = -1, gap_n = 0;
  bit stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
  endtask

  // Expected command stream for an uninterrupted transfer
  task automatic exp_std(input int rab, input bit r, input logic [6:0] dv, input logic [15:0] ra, input int n);
    push(CMD_START, 8'h00); push(CMD_WRITE, {dv, 1'b0}); push(CMD_RD_ACK, 8'h00);
    for (int i = 0; i < rab; i++) begin
      push(CMD_WRITE, (rab == 2 && i == 0) ? ra[15:8] : ra[7:0]); push(CMD_RD_ACK, 8'h00);
    end
    if (n > 0 && !r) begin
      for (int i = 0; i < n; i++) begin push(CMD_WRITE, wq[i]); push(CMD_RD_ACK, 8'h00); end
    end else if (n > 0) begin
      push(CMD_RESTART, 8'h00); push(CMD_WRITE, {dv, 1'b1}); push(CMD_RD_ACK, 8'h00);
      for (int i = 0; i < n; i++) begin
        push(CMD_READ, 8'h00); push(CMD_WR_ACK, (i == n - 1) ? 8'h01 : 8'h00);
        rexp_q.push_back(slave_q[i]);
      end
    end
    push(CMD_STOP, 8'h00);
  endtask

  task automatic go_req(input bit s, input bit r, input logic [6:0] dv, input logic [15:0] ra, input logic [3:0] n);
    sel = s; rw = r; dev = dv; reg16 = ra; len = n; rdack_n = 0; wr_n = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, k;
    d0 = done_n; k = 0;
    while (done_n == d0 && k < budget) begin @(posedge clk); k++; end
    #1;
    chk({tag, "_done"}, done_n - d0, 1);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  // Byte-controller model: checks each strobe against the scoreboard, answers after a short latency
  initial begin : bytectl
    int hold, wait_n;
    bit pend, cur_nack, cur_al;
    logic [3:0] cur;
    logic [11:0] e;
    hold = 0; wait_n = 0; pend = 0; cur_nack = 0; cur_al = 0; cur = CMD_IDLE;
    cmd_ack = 0; i2c_ack = 1; i2c_al = 0; idata = 0;
    forever begin
      @(posedge clk); #1;
      i2c_al = 1'b0;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin cmd_ack = 1'b0; i2c_ack = 1'b1; end
      end
      if (pend) begin
        if (wait_n > 0) wait_n--;
        else if (!cmd_ack) begin
          pend = 0;
          if (cur_al) begin i2c_al = 1'b1; cmd_ack = 1'b1; hold = 1; end
          else begin
            cmd_ack = 1'b1; hold = 2; i2c_ack = ~cur_nack;
            idata = (cur == CMD_READ && slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
          end
        end
      end
      if (trig) begin
        trig_n++;
        chk("one_outstanding", {31'd0, pend}, 0);
        if (exp_q.size() == 0) chk("unexpected_trig", {28'd0, cmd}, CMD_IDLE);
        else begin
          e = exp_q.pop_front();
          chk("cmd", {28'd0, cmd}, {28'd0, e[11:8]});
          if (e[11:8] == CMD_WRITE || e[11:8] == CMD_WR_ACK) chk("data", {24'd0, data}, {24'd0, e[7:0]});
        end
        cur = cmd; wait_n = 2; pend = ~stall;
        cur_nack = (cmd == CMD_RD_ACK) && (rdack_n == nack_at);
        cur_al   = (cmd == CMD_WRITE) && (wr_n == al_at);
        if (cmd == CMD_RD_ACK) rdack_n++;
        if (cmd == CMD_WRITE) wr_n++;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rvalid) begin
        if (rexp_q.size() == 0) chk("unexpected_rvalid", {24'd0, rdata}, 0);
        else chk("rdata", {24'd0, rdata}, {24'd0, rexp_q.pop_front()});
      end
      if (done) done_n++;
    end
  end

  initial begin : feeder
    bit hs;
    int snap;
    snap = 0; wvalid = 0; wdata = 0;
    forever begin
      @(negedge clk);
      hs = wvalid && wready;
      @(posedge clk); #2;
      if (hs) begin
        void'(wq.pop_front()); wvalid = 1'b0; wsent++;
      end else if (!wvalid && wq.size() > 0) begin
        if (wsent == gap_at && gap_n > 0) begin
          gap_n--;
          if (gap_n == 30) snap = trig_n;
          if (gap_n == 0) chk("gap_no_trig", trig_n, snap);
        end else begin
          wvalid = 1'b1; wdata = wq[0];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin : main
    int t0, k, d0;
    enable = 1; go = 0; rw = 0; dev = 0; reg16 = 0; len = 0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);  chk("rst_cmd", {28'd0, cmd0}, CMD_IDLE);
    chk("rst_trig", trig0, 0);  chk("rst_done", done0, 0);
    chk("rst_wready", wready0, 0); chk("rst_flags", {nack0, al0, to0}, 0);
    rstn = 1;
    @(posedge clk); #1;

    wq.push_back(8'h55);
    exp_std(1, 0, 7'h50, 16'h0010, 1);
    go_req(0, 0, 7'h50, 16'h0010, 1);
    wait_done("wr1", 400);
    chk("wr1_nack", nack, 0);

    slave_q.push_back(8'h3C); slave_q.push_back(8'hC3);
    exp_std(1, 1, 7'h50, 16'h0010, 2);
    go_req(0, 1, 7'h50, 16'h0010, 2);
    wait_done("rd2", 600);
    chk("rd2_rdata_all", rexp_q.size(), 0);

    nack_at = 0;
    push(CMD_START, 8'h00); push(CMD_WRITE, 8'hA0); push(CMD_RD_ACK, 8'h00); push(CMD_STOP, 8'h00);
    go_req(0, 0, 7'h50, 16'h0010, 1);
    wait_done("nack", 400);
    chk("nack_flag", nack, 1);
    nack_at = -1;

    al_at = 1;
    push(CMD_START, 8'h00); push(CMD_WRITE, 8'hA0); push(CMD_RD_ACK, 8'h00); push(CMD_WRITE, 8'h10);
    go_req(0, 0, 7'h50, 16'h0010, 1);
    wait_done("al", 400);
    chk("al_flag", al, 1);
    chk("al_nack_clear", nack, 0);
    t0 = trig_n;
    repeat (10) @(posedge clk);
    chk("al_no_stop", trig_n, t0);
    al_at = -1;

    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    wsent = 0; gap_at = 1; gap_n = 50;
    exp_std(1, 0, 7'h50, 16'h0010, 3);
    go_req(0, 0, 7'h50, 16'h0010, 3);
    chk("gap_al_cleared", al, 0);
    wait_done("gap", 1500);
    gap_at = -1;

    exp_std(1, 1, 7'h50, 16'h0010, 0);
    go_req(0, 1, 7'h50, 16'h0010, 0);
    wait_done("rd0", 400);

    exp_std(2, 0, 7'h50, 16'h1234, 0);
    go_req(1, 0, 7'h50, 16'h1234, 0);
    wait_done("ra2", 400);

    sel = 0;
    exp_std(1, 0, 7'h2A, 16'h0077, 0);
    go_req(0, 0, 7'h2A, 16'h0077, 0);
    t0 = trig_n - 1; k = 0; d0 = done_n;
    while (trig_n < t0 + 3 && k < 200) begin @(posedge clk); #3; k++; end
    chk("en_reach_ack", trig_n - t0, 3);
    enable = 0;
    @(posedge clk); #1;
    chk("en_busy", busy, 0);
    chk("en_cmd", {28'd0, cmd}, CMD_IDLE);
    enable = 1;
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("en_no_done", done_n, d0);

`ifdef I2C_TIMEOUT_EN
    push(CMD_START, 8'h00);
    stall = 1'b1;
    go_req(0, 0, 7'h50, 16'h0010, 1);
    wait_done("tmo", 300);
    chk("tmo_flag", tmo, 1);
    stall = 1'b0;
`else
    chk("tmo_off", tmo, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
